// File: rtl/cfg_pkg.sv
// cfg_pkg: FSM state type and width helpers shared by the configuration frame loader.
package cfg_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {IDLE, SHIFT, COMMIT, DONE} cfg_state_t;

    function automatic int clog2_min1(input int n);
        return n <= 2 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_frame_store.sv
// cfg_frame_store: one configuration frame register with true and complement outputs.
module cfg_frame_store #(
    parameter int FRAME_BITS = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  we_i,
    input  logic [FRAME_BITS-1:0] d_i,
    output logic [FRAME_BITS-1:0] q_o,
    output logic [FRAME_BITS-1:0] qn_o
);

    always_ff @(posedge CLK)
        q_o <= RESET ? '0 : we_i ? d_i : q_o;

    assign qn_o = ~q_o;

endmodule

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: serial MSB-first loader filling FRAME_COUNT frames of FRAME_BITS bits.
// Define CFG_READBACK_EN to add the registered rb_addr_i/rb_data_o readback port.
module cfg_frame_loader
    import cfg_pkg::*;
#(
    parameter int FRAME_BITS  = 32,
    parameter int FRAME_COUNT = 20
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              start_i,
    input  logic                              data_i,
    input  logic                              valid_i,
`ifdef CFG_READBACK_EN
    input  logic [clog2_min1(FRAME_COUNT)-1:0] rb_addr_i,
    output logic [FRAME_BITS-1:0]             rb_data_o,
`endif
    output logic                              ready_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [FRAME_BITS*FRAME_COUNT-1:0] cfg_q_o,
    output logic [FRAME_BITS*FRAME_COUNT-1:0] cfg_qn_o
);

    localparam int CW = clog2_min1(FRAME_BITS);
    localparam int AW = clog2_min1(FRAME_COUNT);

    cfg_state_t            state, state_n;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [AW-1:0]         addr, addr_n;
    logic [FRAME_BITS-1:0] frame, frame_n;
    logic [FRAME_BITS-1:0] frame_q [FRAME_COUNT];
    logic                  accept, last_bit, last_frame;

    assign ready_o    = state == SHIFT;
    assign busy_o     = state == SHIFT || state == COMMIT;
    assign done_o     = state == DONE;
    assign accept     = ready_o && valid_i;
    assign last_bit   = bit_cnt == CW'(FRAME_BITS - 1);
    assign last_frame = addr == AW'(FRAME_COUNT - 1);

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        addr_n    = addr;
        frame_n   = frame;
        case (state)
            IDLE: if (start_i) begin
                state_n   = SHIFT;
                bit_cnt_n = '0;
                addr_n    = '0;
            end
            SHIFT: if (accept) begin
                frame_n   = {frame[FRAME_BITS-2:0], data_i};
                bit_cnt_n = last_bit ? bit_cnt : bit_cnt + CW'(1);
                state_n   = last_bit ? COMMIT : SHIFT;
            end
            COMMIT: begin
                state_n   = last_frame ? DONE : SHIFT;
                bit_cnt_n = '0;
                addr_n    = last_frame ? addr : addr + AW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK)
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            addr    <= '0;
            frame   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            addr    <= addr_n;
            frame   <= frame_n;
        end

    for (genvar i = 0; i < FRAME_COUNT; i++) begin : g_frame
        cfg_frame_store #(.FRAME_BITS(FRAME_BITS)) u_store (
            .CLK  (CLK),
            .RESET(RESET),
            .we_i (state == COMMIT && addr == AW'(i)),
            .d_i  (frame),
            .q_o  (frame_q[i]),
            .qn_o (cfg_qn_o[i*FRAME_BITS +: FRAME_BITS])
        );
        assign cfg_q_o[i*FRAME_BITS +: FRAME_BITS] = frame_q[i];
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge CLK)
        rb_data_o <= RESET || int'(rb_addr_i) >= FRAME_COUNT ? '0 : frame_q[rb_addr_i];
`endif

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: directed checks of cfg_frame_loader at 8x2 and at the 2x1 boundary.
module tb_cfg_frame_loader;
    import cfg_pkg::*;

    logic        clk = 0, RESET = 1;
    logic        start = 0, data = 0, valid = 0, ready, busy, done;
    logic [15:0] q, qn;
    logic        start_b = 0, data_b = 0, valid_b = 0, ready_b, busy_b, done_b;
    logic [1:0]  q_b, qn_b;
`ifdef CFG_READBACK_EN
    logic        rb_addr = 0, rb_addr_b = 0;
    logic [7:0]  rb_data;
    logic [1:0]  rb_data_b;
`endif
    int          n_checks = 0, n_fail = 0, done_cyc, done_cnt;

    always #5 clk = ~clk;

    cfg_frame_loader #(.FRAME_BITS(8), .FRAME_COUNT(2)) dut (
        .CLK(clk), .RESET(RESET), .start_i(start), .data_i(data), .valid_i(valid),
`ifdef CFG_READBACK_EN
        .rb_addr_i(rb_addr), .rb_data_o(rb_data),
`endif
        .ready_o(ready), .busy_o(busy), .done_o(done), .cfg_q_o(q), .cfg_qn_o(qn)
    );

    cfg_frame_loader #(.FRAME_BITS(2), .FRAME_COUNT(1)) dut_b (
        .CLK(clk), .RESET(RESET), .start_i(start_b), .data_i(data_b), .valid_i(valid_b),
`ifdef CFG_READBACK_EN
        .rb_addr_i(rb_addr_b), .rb_data_o(rb_data_b),
`endif
        .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b), .cfg_q_o(q_b), .cfg_qn_o(qn_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        RESET = 1;
        step();
        RESET = 0;
    endtask

    // Starts a load, then for ncyc cycles offers the first nbits of bits (MSB first)
    // whenever ready is high; gap inserts an idle valid cycle before every bit.
    task automatic run(input logic [15:0] bits, input int nbits, input bit gap, input int ncyc);
        int idx = 0;
        bit tog = 0;
        done_cyc = -1;
        done_cnt = 0;
        start = 1;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            start = 0;
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            valid = 0;
            if (ready && idx < nbits) begin
                valid = gap ? tog : 1'b1;
                tog = !tog;
                if (valid) begin
                    data = bits[15-idx];
                    idx++;
                end
            end
        end
        valid = 0;
    endtask

    initial begin
        @(negedge clk);
        step();
        check("rst_q", q, 16'h0000);
        check("rst_qn", qn, 16'hFFFF);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RESET = 0;

        run(16'hA53C, 16, 0, 25);
        check("load_done_cyc", done_cyc, 19);
        check("load_done_cnt", done_cnt, 1);
        check("load_q", q, 16'h3CA5);
        check("load_qn", qn, 16'hC35A);
        check("load_idle", dut.state, IDLE);
`ifdef CFG_READBACK_EN
        rb_addr = 1;
        step();
        check("rb_f1", rb_data, 8'h3C);
        rb_addr = 0;
        step();
        check("rb_f0", rb_data, 8'hA5);
`endif

        do_reset();
        check("clr_q", q, 16'h0000);
        run(16'hA53C, 16, 1, 45);
        check("gap_done_cyc", done_cyc, 35);
        check("gap_done_cnt", done_cnt, 1);
        check("gap_q", q, 16'h3CA5);

        do_reset();
        run(16'hA000, 3, 0, 4);
        start = 1;
        step();
        start = 0;
        check("restart_state", dut.state, SHIFT);
        check("restart_cnt", dut.bit_cnt, 3);
        check("restart_addr", dut.addr, 0);

        do_reset();
        run(16'hA53C, 12, 0, 14);
        check("abort_pre_q", q, 16'h00A5);
        check("abort_pre_busy", busy, 1);
        RESET = 1;
        step();
        RESET = 0;
        check("abort_q", q, 16'h0000);
        check("abort_qn", qn, 16'hFFFF);
        check("abort_state", dut.state, IDLE);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);

        begin
            int idx = 0;
            logic [1:0] bits_b = 2'b10;
            done_cyc = -1;
            start_b = 1;
            for (int c = 1; c <= 8; c++) begin
                step();
                start_b = 0;
                if (done_b && done_cyc < 0) done_cyc = c;
                valid_b = ready_b && idx < 2;
                if (valid_b) begin
                    data_b = bits_b[1-idx];
                    idx++;
                end
            end
            valid_b = 0;
        end
        check("b_done_cyc", done_cyc, 4);
        check("b_q", q_b, 2'b10);
        check("b_qn", qn_b, 2'b01);
        check("b_addr", dut_b.addr, 0);
        check("b_addr_w", $bits(dut_b.addr), 1);
`ifdef CFG_READBACK_EN
        rb_addr_b = 1;
        step();
        check("b_rb_oob", rb_data_b, 2'b00);
        rb_addr_b = 0;
        step();
        check("b_rb_f0", rb_data_b, 2'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
